// File: rtl/spi_byte_responder_if.sv
// Pin and stream bundle for spi_byte_responder: SPI pins toward the board header,
// ready/valid byte stream plus status pulses toward the register file.
interface spi_byte_responder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cs;
    logic                  sck;
    logic                  mosi;
    logic                  miso;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  busy;
    logic                  frame_err;
    logic                  overrun;

    modport slave (
        input  cs, sck, mosi, ready,
        output miso, data, valid, busy, frame_err, overrun
    );

    modport master (
        output cs, sck, mosi, ready,
        input  miso, data, valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/spi_byte_responder.sv
// SPI mode-0 responder: oversamples cs/sck/mosi in the clk domain, delivers each
// complete frame on ready/valid and echoes the previously received byte on miso.
module spi_byte_responder #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    SYNC_STAGES  = 2,
    parameter logic [DATA_WIDTH-1:0] TX_RESET_VAL = '0
) (
    input logic                 clk,
    input logic                 reset_n,
    spi_byte_responder_if.slave bus
);
    localparam int               CNT_W    = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   armed_q, armed_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0]  echo_q, echo_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   miso_q, miso_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    logic cs_s, sck_s, mosi_s;
    logic cs_fall, cs_rise, sck_rise, sck_fall;

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = ~sck_prev_q & sck_s & ~cs_s;
    assign sck_fall = sck_prev_q & ~sck_s & ~cs_s;

    // The synchronizers come out of reset holding idle levels, so armed only trusts
    // cs once fill_q shows the last stage carries a real pin sample.
    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        cs_prev_d   = cs_s;
        sck_prev_d  = sck_s;
        armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall && armed_q) state_d = SHIFT;
            SHIFT:   if (cs_rise)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        echo_d      = echo_q;
        data_d      = data_q;
        valid_d     = valid_q & ~bus.ready;
        miso_d      = miso_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall && armed_q) begin
                    bit_cnt_d = '0;
                    tx_sr_d   = echo_q;
                    miso_d    = echo_q[DATA_WIDTH-1];
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    miso_d = 1'b0;
                    if (bit_cnt_q != CNT_FULL) begin
                        frame_err_d = 1'b1;
                    end else if (!valid_q || bus.ready) begin
                        data_d  = rx_sr_q;
                        echo_d  = rx_sr_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    if (sck_rise) begin
                        rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
                        if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    // Zeros shift in behind the echo byte, so bits past the end read 0.
                    if (sck_fall) begin
                        tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                        miso_d  = tx_sr_q[DATA_WIDTH-2];
                    end
                end
            end
            default: miso_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            echo_q      <= TX_RESET_VAL;
            data_q      <= '0;
            valid_q     <= 1'b0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            fill_q      <= fill_d;
            cs_prev_q   <= cs_prev_d;
            sck_prev_q  <= sck_prev_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            echo_q      <= echo_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            miso_q      <= miso_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = ~cs_s;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_spi_byte_responder.sv
// Bench for spi_byte_responder: directed SPI frames plus random ones, checked against
// a frame-level model of delivery, echo, overrun and frame_err.
module tb_spi_byte_responder;
    localparam int           W   = 8;
    localparam int           SS  = 2;
    localparam logic [W-1:0] TXR = 8'h00;

    logic        clk = 1'b0;
    logic        reset_n;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    spi_byte_responder_if #(.DATA_WIDTH(W)) bus();

    spi_byte_responder #(
        .DATA_WIDTH(W), .SYNC_STAGES(SS), .TX_RESET_VAL(TXR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed side, sampled on the falling edge.
    logic [W-1:0] got_q[$];
    int           fe_cnt = 0;
    int           ov_cnt = 0;
    int           vhi_cnt = 0;
    int unsigned  vrise_cyc = 0;
    logic         v_prev = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.valid && bus.ready) got_q.push_back(bus.data);
            if (bus.frame_err) fe_cnt <= fe_cnt + 1;
            if (bus.overrun) ov_cnt <= ov_cnt + 1;
            if (bus.valid && !v_prev) vrise_cyc <= cyc;
            if (bus.valid) vhi_cnt <= vhi_cnt + 1;
        end
        v_prev <= bus.valid;
    end

    // Frame-level model.
    logic [W-1:0] exp_q[$];
    int           exp_fe = 0;
    int           exp_ov = 0;
    logic         m_valid;
    logic [W-1:0] m_data, m_echo;
    int unsigned  csr_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_ready(input logic v);
        bus.ready = v;
        if (v && m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
        end
        tick(3);
    endtask

    // rst_at >= 0 pulses reset before that bit; rdy_pulse raises ready for exactly
    // the edge on which the frame completes.
    task automatic do_frame(input logic [15:0] bits, input int nbits, input int rst_at,
                            input bit rdy_pulse);
        logic [15:0]  got_m;
        logic [15:0]  exp_m;
        logic [W-1:0] echo;
        echo  = m_echo;
        got_m = '0;
        exp_m = '0;
        bus.cs   = 1'b0;
        bus.mosi = (nbits > 0) ? bits[nbits-1] : 1'b0;
        tick(8);
        if (rst_at < 0) chk("busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset_n = 1'b0;
                tick(3);
                reset_n = 1'b1;
                m_valid = 1'b0;
                m_echo  = TXR;
                tick(2);
            end
            bus.sck = 1'b1;
            got_m = {got_m[14:0], bus.miso};
            exp_m = {exp_m[14:0], (i < W) ? echo[W-1-i] : 1'b0};
            tick(8);
            bus.sck = 1'b0;
            if (i + 1 < nbits) bus.mosi = bits[nbits-2-i];
            tick(8);
        end
        bus.cs  = 1'b1;
        csr_cyc = cyc;
        if (rdy_pulse) begin
            tick(2);
            bus.ready = 1'b1;
            tick(1);
            bus.ready = 1'b0;
            tick(13);
        end else begin
            tick(16);
        end
        if (rst_at < 0) begin
            if (nbits != W) exp_fe++;
            else if (!m_valid || bus.ready || rdy_pulse) begin
                if (m_valid) exp_q.push_back(m_data);
                m_data  = bits[W-1:0];
                m_echo  = bits[W-1:0];
                m_valid = 1'b1;
            end else exp_ov++;
            if (m_valid && bus.ready) begin
                exp_q.push_back(m_data);
                m_valid = 1'b0;
            end
            if (nbits > 0) chk("miso", 32'(got_m), 32'(exp_m));
        end
        chk("frame_err", 32'(fe_cnt), 32'(exp_fe));
        chk("overrun", 32'(ov_cnt), 32'(exp_ov));
        chk("n_dlv", 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk("dlv", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
        chk("valid", 32'(bus.valid), 32'(m_valid));
        if (m_valid) chk("data", 32'(bus.data), 32'(m_data));
    endtask

    initial begin
        int vh0;
        int r;
        int nb;
        reset_n   = 1'b0;
        bus.cs    = 1'b1;
        bus.sck   = 1'b0;
        bus.mosi  = 1'b0;
        bus.ready = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_echo    = TXR;
        tick(3);
        chk("rst", 32'({bus.valid, bus.data, bus.miso, bus.busy, bus.frame_err, bus.overrun}), 32'd0);
        reset_n = 1'b1;
        tick(10);
        chk("idle", 32'({bus.valid, bus.miso, bus.busy}), 32'd0);

        // Single byte, latency and one-cycle valid pulse with ready held.
        set_ready(1'b1);
        vh0 = vhi_cnt;
        do_frame(16'h00A5, W, -1, 1'b0);
        chk("lat", vrise_cyc - csr_cyc, 32'(SS + 1));
        chk("vpulse", 32'(vhi_cnt - vh0), 32'd1);

        // Echo chain.
        do_frame(16'h003C, W, -1, 1'b0);
        do_frame(16'h00C3, W, -1, 1'b0);

        // Backpressure: overrun keeps the held byte and the echo.
        set_ready(1'b0);
        do_frame(16'h0011, W, -1, 1'b0);
        do_frame(16'h0022, W, -1, 1'b0);
        do_frame(16'h0033, W, -1, 1'b0);
        set_ready(1'b1);

        // Short, long and empty frames.
        do_frame(16'h0055, 7, -1, 1'b0);
        do_frame(16'h01AB, 9, -1, 1'b0);
        do_frame(16'h0000, 0, -1, 1'b0);
        do_frame(16'h0096, W, -1, 1'b0);

        // Reset mid-frame, then a clean frame.
        do_frame(16'h00F0, W, 4, 1'b0);
        do_frame(16'h005A, W, -1, 1'b0);

        // Handshake on the completing edge.
        set_ready(1'b0);
        do_frame(16'h0066, W, -1, 1'b0);
        do_frame(16'h0077, W, -1, 1'b1);
        set_ready(1'b1);

        for (int k = 0; k < 24; k++) begin
            r  = int'($urandom_range(0, 9));
            nb = (r < 7) ? W : (r == 7) ? 7 : (r == 8) ? 9 : 0;
            if ($urandom_range(0, 3) == 0) set_ready(~bus.ready);
            do_frame(16'($urandom), nb, -1, 1'b0);
        end
        set_ready(1'b1);
        do_frame(16'h00E1, W, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
